// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: decodes START/len/payload frames into a ping-pong payload buffer with
// a registered read port, one-cycle status pulses and a rotating LED display.
// Optional trailing checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module uart_frame_decoder #(
  parameter int unsigned MAX_BYTES   = 16,
  parameter logic [7:0]  START_BYTE  = 8'h7E,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned DISP_DIV    = 50_000_000,
  localparam int unsigned AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          msg_valid,
  output logic [7:0]    msg_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_csum,
  output logic          busy,
  output logic [7:0]    led
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned DW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {HEAD, BCNT, BODY, CSUM, COMMIT} state_e;
`else
  typedef enum logic [2:0] {HEAD, BCNT, BODY, COMMIT} state_e;
`endif

  state_e        state_q;
  logic [7:0]    widx_q;
  logic [7:0]    wlen_q;
  logic [TW-1:0] to_q;
  logic          bank_q;
  logic [7:0]    msg_len_q;
  logic          msg_valid_q;
  logic          err_len_q;
  logic          err_to_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    led_q;
  logic [7:0]    didx_q;
  logic [DW-1:0] tc_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    sum_q;
  logic          err_csum_q;
`endif

  // bank_q selects the committed bank; the other one is the working bank.
  logic [7:0] mem_q [2][MAX_BYTES];

  logic accept;
  logic tick;
  logic expire;
  logic rd_hit;

  always_comb begin
    accept = in_valid && in_ready;
    tick   = (tc_q == DW'(DISP_DIV - 1));
    expire = !accept && (state_q != HEAD) && (state_q != COMMIT) &&
             (to_q == TW'(TIMEOUT_CYC - 1));
    rd_hit = (8'(rd_addr) < msg_len_q);
  end

  always_ff @(posedge CLK) begin
    if (!reset && accept && state_q == BODY) begin
      mem_q[~bank_q][widx_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= HEAD;
      widx_q      <= '0;
      wlen_q      <= '0;
      to_q        <= '0;
      bank_q      <= 1'b0;
      msg_len_q   <= '0;
      msg_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
      rd_data_q   <= '0;
      led_q       <= '0;
      didx_q      <= '0;
      tc_q        <= '0;
`ifdef FRAME_CHECKSUM_EN
      sum_q       <= '0;
      err_csum_q  <= 1'b0;
`endif
    end else begin
      msg_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      err_csum_q  <= 1'b0;
`endif
      rd_data_q <= rd_hit ? mem_q[bank_q][rd_addr] : '0;

      tc_q <= tick ? '0 : tc_q + DW'(1);
      if (tick) begin
        if (msg_len_q == '0) begin
          led_q  <= '0;
          didx_q <= '0;
        end else begin
          led_q  <= mem_q[bank_q][didx_q[AW-1:0]];
          didx_q <= (didx_q == msg_len_q - 8'd1) ? '0 : didx_q + 8'd1;
        end
      end

      if (state_q == HEAD || accept) to_q <= '0;
      else                           to_q <= to_q + TW'(1);

      case (state_q)
        HEAD: begin
          if (accept && in_data == START_BYTE) begin
            state_q <= BCNT;
            widx_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        BCNT: begin
          if (accept) begin
            if (in_data == '0 || in_data > 8'(MAX_BYTES)) begin
              err_len_q <= 1'b1;
              state_q   <= HEAD;
            end else begin
              wlen_q  <= in_data;
              state_q <= BODY;
            end
          end
        end
        BODY: begin
          if (accept) begin
            widx_q <= widx_q + 8'd1;
`ifdef FRAME_CHECKSUM_EN
            sum_q  <= sum_q + in_data;
            if (widx_q == wlen_q - 8'd1) state_q <= CSUM;
`else
            if (widx_q == wlen_q - 8'd1) state_q <= COMMIT;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            if (in_data == sum_q) begin
              state_q <= COMMIT;
            end else begin
              err_csum_q <= 1'b1;
              state_q    <= HEAD;
            end
          end
        end
`endif
        COMMIT: begin
          // Commit overrides any same-cycle display step so the next tick starts at byte 0.
          bank_q      <= ~bank_q;
          msg_len_q   <= wlen_q;
          msg_valid_q <= 1'b1;
          didx_q      <= '0;
          state_q     <= HEAD;
        end
        default: state_q <= HEAD;
      endcase

      if (expire) begin
        state_q  <= HEAD;
        err_to_q <= 1'b1;
        to_q     <= '0;
      end
    end
  end

  assign in_ready    = (state_q != COMMIT);
  assign busy        = (state_q != HEAD);
  assign msg_valid   = msg_valid_q;
  assign msg_len     = msg_len_q;
  assign rd_data     = rd_data_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;
  assign led         = led_q;
`ifdef FRAME_CHECKSUM_EN
  assign err_csum    = err_csum_q;
`else
  assign err_csum    = 1'b0;
`endif

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16: maximum payload bytes per frame, from 1 to 255.
REQ-002 SHALL have parameter START_BYTE, default 8'h7E: frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000: idle cycles allowed mid-frame before the frame is abandoned.
REQ-004 SHALL have parameter DISP_DIV, default 50_000_000: CLK cycles per LED display step.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1): byte stream from the UART unloader; a byte is accepted when in_valid && in_ready.
REQ-008 SHALL have port msg_valid, output, 1: one-cycle pulse when a frame is committed.
REQ-009 SHALL have port msg_len, output, 8: length of the last committed frame.
REQ-010 SHALL have ports rd_addr (input, clog2(MAX_BYTES)) and rd_data (output, 8): read port into the committed payload.
REQ-011 SHALL have ports err_len, err_timeout and err_csum, each output, 1: one-cycle error pulses.
REQ-012 SHALL have port busy, output, 1: high whenever state is not HEAD.
REQ-013 SHALL have port led, output, 8: rotating display of the committed payload.

Function
REQ-014 SHALL implement states HEAD, BCNT, BODY, CSUM and COMMIT; only accepted bytes advance HEAD, BCNT, BODY and CSUM.
REQ-015 In HEAD, SHALL go to BCNT on byte == START_BYTE, clear the working index and clear the running sum; any other byte SHALL be dropped.
REQ-016 In BCNT, a count of 0 or > MAX_BYTES SHALL pulse err_len and return to HEAD; otherwise SHALL latch the working length and go to BODY.
REQ-017 In BODY, SHALL write the byte to the working bank at the working index, increment the index and add the byte to the sum mod 256; after byte len-1, SHALL go to CSUM when FRAME_CHECKSUM_EN is defined and to COMMIT otherwise.
REQ-018 In CSUM, a byte equal to the sum SHALL go to COMMIT; a mismatch SHALL pulse err_csum, return to HEAD and discard the frame.
REQ-019 COMMIT SHALL last one cycle with in_ready=0, swap banks (working becomes committed), update msg_len, pulse msg_valid and return to HEAD. in_ready SHALL be 1 in every other state.
REQ-020 Payload storage SHALL be two banks of MAX_BYTES x 8, ping-pong; an abandoned frame SHALL never disturb the committed bank.
REQ-021 rd_data SHALL be registered, 1-cycle latency, from the committed bank; rd_addr >= msg_len SHALL return 8'h00; the read in the cycle after COMMIT SHALL return new-bank data.
REQ-022 The timeout counter SHALL reset on every accepted byte and in HEAD, and increment otherwise; on reaching TIMEOUT_CYC it SHALL pulse err_timeout and return to HEAD. A byte accepted in the expiry cycle SHALL win: no timeout, and the byte is processed.
REQ-023 The display tick SHALL fire every DISP_DIV cycles; on a tick led SHALL be 8'h00 if msg_len==0, else committed[idx], with idx wrapping from msg_len-1 to 0.
REQ-024 COMMIT SHALL reset idx to 0, so the next tick shows byte 0 of the new frame.
REQ-025 START_BYTE received in BODY SHALL be stored as data, with no resync.

Reset
REQ-026 Reset SHALL set state HEAD and msg_len 0; msg_valid, err_len, err_timeout, err_csum, busy, rd_data and led to 0; in_ready 1; idx, tick counter, timeout counter and bank select to 0.
REQ-027 Reset mid-frame SHALL abandon the frame and emit no error pulse; bank contents need not be cleared, because msg_len=0 masks them.

Configuration
REQ-028 With FRAME_CHECKSUM_EN defined, every frame SHALL carry a trailing sum byte checked per REQ-018.
REQ-029 Without FRAME_CHECKSUM_EN, SHALL omit CSUM state and sum logic, BODY SHALL go directly to COMMIT, and err_csum SHALL be tied 0.

Verification
REQ-030 Send 7E,03,11,22,33 (plus 66 when checksum enabled) -> one msg_valid pulse, msg_len=3, rd_addr 0..2 returns 11,22,33, rd_addr 3 returns 00.
REQ-031 Send 7E,00 and then 7E,11 (MAX_BYTES=16) -> err_len pulses twice, msg_len unchanged, state HEAD.
REQ-032 Send 7E,04,AA and then idle TIMEOUT_CYC cycles -> err_timeout pulses once, busy falls, prior committed data intact.
REQ-033 With checksum enabled, send 7E,02,01,02,04 -> err_csum pulses, no msg_valid; then 7E,02,01,02,03 -> commit with msg_len=2.
REQ-034 With DISP_DIV=4 and committed 11,22,33 -> led steps 11,22,33,11 on successive ticks; a new commit resets led to byte 0 of the new frame on the next tick.
REQ-035 Assert reset midway through BODY -> all outputs reach REQ-026 values next cycle, no pulses, and the next full frame commits correctly.
